// File: rtl/iiravg_inverse.sv
// iiravg_inverse: recovers the input of a first-order recursive averager from its output stream.
// Computes x_est = y[n-1] + 2^LGALPHA*(y[n]-y[n-1]), rescales from IW to OW bits and saturates.
// Ports: i_clk, i_reset (async, active high), i_ce/i_data (averaged sample in),
//   i_sync (next accepted sample only primes history), o_ce/o_data/o_sat (recovered sample out).
// Optional IIRAVG_INVERSE_SATCOUNT_EN adds o_satcount, a saturating count of clipped outputs.
module iiravg_inverse #(
  parameter int IW = 16,
  parameter int OW = 15,
  parameter int LGALPHA = 4,
  parameter logic [IW-1:0] RESET_VALUE = '0,
  parameter bit PRIMED_RESET = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [IW-1:0] i_data,
  input  logic          i_sync,
  output logic          o_ce,
  output logic [OW-1:0] o_data,
  output logic          o_sat
`ifdef IIRAVG_INVERSE_SATCOUNT_EN
  , output logic [15:0] o_satcount
`endif
);
  localparam int SW = IW + LGALPHA + 2;
  localparam logic signed [SW-1:0] MAXV = SW'(2**(OW-1) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);
  typedef enum logic {PRIME, RUN} state_t;
  state_t state;
  logic [IW-1:0] prev, p;
  logic [IW:0] d, d_next;
  logic v1, take, hi, lo;
  logic signed [SW-1:0] s, r;
  assign take = i_ce && state == RUN && !i_sync;
  // y[n]-y[n-1] gets one extra bit so the difference of two full-scale samples cannot wrap
  assign d_next = {i_data[IW-1], i_data} - {prev[IW-1], prev};
  // s is wide enough for the scaled difference plus history, so only the output ever clips
  assign s = {{(SW-IW){p[IW-1]}}, p} + ({{(SW-IW-1){d[IW]}}, d} <<< LGALPHA);
  assign r = s >>> (IW - OW);
  assign hi = r > MAXV;
  assign lo = r < MINV;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state  <= PRIMED_RESET ? RUN : PRIME;
      prev   <= RESET_VALUE;
      p      <= '0;
      d      <= '0;
      v1     <= 1'b0;
      o_ce   <= 1'b0;
      o_data <= '0;
      o_sat  <= 1'b0;
    end else begin
      v1 <= take;
      if (i_ce) prev <= i_data;
      if (take) begin
        d <= d_next;
        p <= prev;
      end
      // a sample arriving with i_sync is itself the priming sample, so the block resumes RUN
      state <= i_ce ? RUN : i_sync ? PRIME : state;
      o_ce <= v1;
      if (v1) begin
        o_data <= hi ? MAXV[OW-1:0] : lo ? MINV[OW-1:0] : r[OW-1:0];
        o_sat  <= hi || lo;
      end
    end
`ifdef IIRAVG_INVERSE_SATCOUNT_EN
  // counted on the edge that raises o_ce, so the count already includes the sample being presented
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) o_satcount <= '0;
    else if (i_sync) o_satcount <= '0;
    else if (v1 && (hi || lo) && o_satcount != 16'hFFFF) o_satcount <= o_satcount + 16'd1;
`endif
endmodule

// File: tb/tb_iiravg_inverse.sv
// tb_iiravg_inverse: directed and loopback checks of the recursive-averager inverse.
module tb_iiravg_inverse;
  logic i_clk = 1'b0, i_reset = 1'b0, i_ce = 1'b0, i_sync = 1'b0;
  logic [15:0] i_data = '0;
  logic o_ce, o_sat;
  logic [14:0] o_data;
`ifdef IIRAVG_INVERSE_SATCOUNT_EN
  logic [15:0] o_satcount;
`endif
  int n_chk = 0, n_ok = 0;

  iiravg_inverse dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data), .i_sync(i_sync),
    .o_ce(o_ce), .o_data(o_data), .o_sat(o_sat)
`ifdef IIRAVG_INVERSE_SATCOUNT_EN
    , .o_satcount(o_satcount)
`endif
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [15:0] d, input logic s);
    @(negedge i_clk);
    i_ce = 1'b1;
    i_data = d;
    i_sync = s;
    @(negedge i_clk);
    i_ce = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic get(input string tag, input logic [14:0] exp_d, input logic exp_s);
    int k = 0;
    while (!o_ce && k < 4) begin
      @(negedge i_clk);
      k++;
    end
    check({tag, "_ce"}, o_ce, 1);
    check({tag, "_data"}, o_data, exp_d);
    check({tag, "_sat"}, o_sat, exp_s);
  endtask

  task automatic do_reset();
    #1 i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    logic seen;
    int xq[$];
    int sent, got, y, x, o;
    do_reset();
    check("rst_ce", o_ce, 0);
    check("rst_data", o_data, 0);
    check("rst_sat", o_sat, 0);
    // step: latency exactly two edges, then hold
    send(16'h0200, 1'b0);
    check("lat_early", o_ce, 0);
    @(negedge i_clk);
    check("step_ce", o_ce, 1);
    check("step_data", o_data, 15'h1000);
    check("step_sat", o_sat, 0);
    @(negedge i_clk);
    check("step_ce_drop", o_ce, 0);
    check("step_hold", o_data, 15'h1000);
    // first 0x2000 after prev=0x0200 overshoots and clips; second is steady state
    send(16'h2000, 1'b0);
    get("jump", 15'h3FFF, 1'b1);
    send(16'h2000, 1'b0);
    get("steady", 15'h1000, 1'b0);
    // saturation from a clean reset
    do_reset();
    send(16'h7FFF, 1'b0);
    get("sat_pos", 15'h3FFF, 1'b1);
    send(16'h8000, 1'b0);
    get("sat_neg", 15'h4000, 1'b1);
`ifdef IIRAVG_INVERSE_SATCOUNT_EN
    check("satcount", o_satcount, 2);
`endif
    // priming
    @(negedge i_clk);
    i_sync = 1'b1;
    @(negedge i_clk);
    i_sync = 1'b0;
`ifdef IIRAVG_INVERSE_SATCOUNT_EN
    check("satcount_sync", o_satcount, 0);
`endif
    send(16'h1234, 1'b0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      seen |= o_ce;
    end
    check("prime_no_out", seen, 0);
    send(16'h1234, 1'b0);
    get("prime", 15'h091A, 1'b0);
    // sync and sample together: that sample primes, the next one produces output
    send(16'h0400, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      seen |= o_ce;
    end
    check("sync_ce_no_out", seen, 0);
    send(16'h0400, 1'b0);
    get("sync_ce", 15'h0200, 1'b0);
    // reset with a sample in flight
    send(16'h0100, 1'b0);
    #1 i_reset = 1'b1;
    #1;
    check("midrst_ce", o_ce, 0);
    check("midrst_data", o_data, 0);
    check("midrst_sat", o_sat, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      seen |= o_ce;
    end
    check("midrst_no_out", seen, 0);
    // loopback through a model of the forward averager
    sent = 0;
    got = 0;
    y = 0;
    for (int c = 0; c < 10010 && got < 10000; c++) begin
      @(negedge i_clk);
      if (o_ce && xq.size() > 0) begin
        x = xq.pop_front();
        o = int'($signed(o_data));
        check("loop", (o <= x && o >= x - 8), 1);
        got++;
      end
      if (sent < 10000) begin
        x = int'($urandom_range(32767)) - 16384;
        y = y + ((2 * x - y) >>> 4);
        i_ce = 1'b1;
        i_data = 16'(y);
        xq.push_back(x);
        sent++;
      end else i_ce = 1'b0;
    end
    check("loop_count", got, 10000);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
